// File: rtl/io_pkg.sv
// Shared definitions for the I/O port bank: default sizes and select decoding.
// Both the write and read paths classify their one-hot selects with classify_sel.
package io_pkg;

  localparam int NPORTS_DEFAULT = 16;
  localparam int W_DEFAULT      = 4;

  // Widest select vector the helpers accept; narrower selects are zero-extended.
  localparam int MAX_PORTS = 64;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONE,
    SEL_MULTI
  } sel_kind_e;

  // Exactly one bit set: clearing the lowest set bit must leave nothing behind.
  function automatic logic is_onehot(input logic [MAX_PORTS-1:0] sel);
    return (sel != '0) && ((sel & (sel - MAX_PORTS'(1))) == '0);
  endfunction

  function automatic sel_kind_e classify_sel(input logic [MAX_PORTS-1:0] sel);
    if (sel == '0) begin
      return SEL_NONE;
    end else if (is_onehot(sel)) begin
      return SEL_ONE;
    end else begin
      return SEL_MULTI;
    end
  endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for one W-bit external input port.
// Both stages clear on reset so a freshly reset bank reads zeros.
module io_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: non-blocking assignments let both stages sample their old values on
  // the same edge; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Bank of NPORTS registered output latches with new-data flags, plus a
// synchronized input-port read mux; illegal selects raise a sticky sel_err.
module io_port_bank
  import io_pkg::*;
#(
  parameter int NPORTS = NPORTS_DEFAULT,
  parameter int W      = W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORTS-1:0]   wr_onehot,
  input  logic [W-1:0]        wr_data,
  input  logic [NPORTS-1:0]   rd_onehot,
  output logic [W-1:0]        rd_data,
  input  logic [NPORTS*W-1:0] in_ports,
  output logic [NPORTS*W-1:0] out_ports,
  output logic [NPORTS-1:0]   out_valid,
  input  logic [NPORTS-1:0]   out_ack,
  output logic                sel_err
);

  sel_kind_e             wr_kind;
  sel_kind_e             rd_kind;
  logic [NPORTS-1:0]     wr_en;
  logic [NPORTS-1:0]     out_valid_next;
  logic [NPORTS*W-1:0]   in_sync;
  logic [W-1:0]          rd_mux;

  // Every external pin crosses into the clk domain before it can be read.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_sync
    io_sync2 #(
      .W(W)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (in_ports[gi*W +: W]),
      .q    (in_sync[gi*W +: W])
    );
  end

  always_comb begin
    wr_kind = classify_sel(MAX_PORTS'(wr_onehot));
    rd_kind = classify_sel(MAX_PORTS'(rd_onehot));
  end

  // A multi-hot write select enables nothing.
  always_comb begin
    wr_en = (wr_kind == SEL_ONE) ? wr_onehot : '0;
  end

  // Ack clears the flag, but a same-cycle write to that port re-sets it.
  always_comb begin
    out_valid_next = wr_en | (out_valid & ~out_ack);
  end

  // The AND-OR mux is only trusted when the select is a legal one-hot.
  always_comb begin
    // NOTE: assigning a default before the loop keeps every path driven, so
    // no latch is inferred for rd_mux.
    rd_mux = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (rd_onehot[i]) begin
        rd_mux = rd_mux | in_sync[i*W +: W];
      end
    end
  end

  // NOTE: the output latch array is reset on purpose: consumers must see
  // all-zero ports immediately on reset, not stale data from before it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_ports <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (wr_en[i]) begin
          out_ports[i*W +: W] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
    end else begin
      out_valid <= out_valid_next;
    end
  end

  // Empty or illegal read selects leave the previous result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_kind == SEL_ONE) begin
      rd_data <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if ((wr_kind == SEL_MULTI) || (rd_kind == SEL_MULTI)) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_io_port_bank;

  localparam int NP = 16;
  localparam int DW = 4;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    wr_onehot;
  logic [DW-1:0]    wr_data;
  logic [NP-1:0]    rd_onehot;
  logic [DW-1:0]    rd_data;
  logic [NP*DW-1:0] in_ports;
  logic [NP*DW-1:0] out_ports;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_ack;
  logic             sel_err;

  int total = 0;
  int bad   = 0;

  io_port_bank #(
    .NPORTS(NP),
    .W     (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_onehot(wr_onehot),
    .wr_data  (wr_data),
    .rd_onehot(rd_onehot),
    .rd_data  (rd_data),
    .in_ports (in_ports),
    .out_ports(out_ports),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: port contents, flags, last read, error, pin history.
  logic [DW-1:0]    m_out [NP];
  logic [NP-1:0]    m_valid;
  logic [DW-1:0]    m_rd;
  logic             m_err;
  logic [NP*DW-1:0] pin_q[$];

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_out[i] = '0;
    m_valid = '0;
    m_rd    = '0;
    m_err   = 1'b0;
    pin_q.delete();
    pin_q.push_back('0);
    pin_q.push_back('0);
  endtask

  // A read sees the pins as they were two edges before the current one.
  task automatic model_edge();
    int               wn;
    int               rn;
    logic [NP*DW-1:0] old_pins;
    wn       = $countones(wr_onehot);
    rn       = $countones(rd_onehot);
    old_pins = pin_q[0];
    for (int i = 0; i < NP; i++) begin
      if (out_ack[i]) m_valid[i] = 1'b0;
    end
    if (wn == 1) begin
      for (int i = 0; i < NP; i++) begin
        if (wr_onehot[i]) begin
          m_out[i]   = wr_data;
          m_valid[i] = 1'b1;
        end
      end
    end
    if (rn == 1) begin
      for (int i = 0; i < NP; i++) begin
        if (rd_onehot[i]) m_rd = old_pins[i*DW +: DW];
      end
    end
    if (wn > 1 || rn > 1) m_err = 1'b1;
    pin_q.push_back(in_ports);
    void'(pin_q.pop_front());
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NP*DW-1:0] exp_out;
    for (int i = 0; i < NP; i++) exp_out[i*DW +: DW] = m_out[i];
    check({tag, ".out_ports"}, 64'(out_ports), 64'(exp_out));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".rd_data"},   64'(rd_data),   64'(m_rd));
    check({tag, ".sel_err"},   64'(sel_err),   64'(m_err));
  endtask

  // Inputs change only at 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_onehot = '0;
    wr_data   = '0;
    rd_onehot = '0;
    out_ack   = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [NP-1:0] pick_sel(input int one_pct, input int multi_pct);
    int r;
    int a;
    int b;
    r = $urandom_range(0, 99);
    a = $urandom_range(0, NP-1);
    b = (a + 1 + $urandom_range(0, NP-2)) % NP;
    if (r < one_pct) return NP'(1) << a;
    if (r < one_pct + multi_pct) return (NP'(1) << a) | (NP'(1) << b);
    return '0;
  endfunction

  typedef struct {
    logic [NP-1:0]    wr;
    logic [DW-1:0]    wd;
    logic [NP-1:0]    rd;
    logic [NP-1:0]    ack;
    logic [NP*DW-1:0] exp_out;
    logic [NP-1:0]    exp_valid;
    logic [DW-1:0]    exp_rd;
    logic             exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    reset    = 1'b1;
    in_ports = '0;
    idle_inputs();

    // Pin i carries the value i throughout the vector table.
    in_ports = 64'hFEDC_BA98_7654_3210;
    apply_reset();
    check_all("reset");

    vecs[0]  = '{16'h0008, 4'hA, 16'h0000, 16'h0000, 64'h0000_0000_0000_A000, 16'h0008, 4'h0, 1'b0};
    vecs[1]  = '{16'h0008, 4'h5, 16'h0000, 16'h0008, 64'h0000_0000_0000_5000, 16'h0008, 4'h0, 1'b0};
    vecs[2]  = '{16'h0000, 4'h0, 16'h0000, 16'h0008, 64'h0000_0000_0000_5000, 16'h0000, 4'h0, 1'b0};
    vecs[3]  = '{16'h0000, 4'h0, 16'h0080, 16'h0008, 64'h0000_0000_0000_5000, 16'h0000, 4'h7, 1'b0};
    vecs[4]  = '{16'h8000, 4'h9, 16'h0000, 16'h0000, 64'h9000_0000_0000_5000, 16'h8000, 4'h7, 1'b0};
    vecs[5]  = '{16'h0001, 4'h1, 16'h0001, 16'h0000, 64'h9000_0000_0000_5001, 16'h8001, 4'h0, 1'b0};
    vecs[6]  = '{16'h0000, 4'h0, 16'h0010, 16'h0000, 64'h9000_0000_0000_5001, 16'h8001, 4'h4, 1'b0};
    vecs[7]  = '{16'h0000, 4'h0, 16'h0000, 16'h0000, 64'h9000_0000_0000_5001, 16'h8001, 4'h4, 1'b0};
    vecs[8]  = '{16'h0011, 4'hF, 16'h0000, 16'h0000, 64'h9000_0000_0000_5001, 16'h8001, 4'h4, 1'b1};
    vecs[9]  = '{16'h0000, 4'h0, 16'h0003, 16'h0000, 64'h9000_0000_0000_5001, 16'h8001, 4'h4, 1'b1};
    vecs[10] = '{16'h0000, 4'h0, 16'h0000, 16'hFFFF, 64'h9000_0000_0000_5001, 16'h0000, 4'h4, 1'b1};

    for (int v = 0; v < 11; v++) begin
      wr_onehot = vecs[v].wr;
      wr_data   = vecs[v].wd;
      rd_onehot = vecs[v].rd;
      out_ack   = vecs[v].ack;
      tick();
      check($sformatf("vec%0d.out_ports", v), 64'(out_ports), 64'(vecs[v].exp_out));
      check($sformatf("vec%0d.out_valid", v), 64'(out_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d.rd_data", v),   64'(rd_data),   64'(vecs[v].exp_rd));
      check($sformatf("vec%0d.sel_err", v),   64'(sel_err),   64'(vecs[v].exp_err));
    end
    idle_inputs();

    // Read of a held pin, then the result holds while the pins move.
    in_ports = '0;
    in_ports[7*DW +: DW] = 4'hC;
    apply_reset();
    tick();
    tick();
    rd_onehot = 16'h0080;
    tick();
    check("hold_read.first", 64'(rd_data), 64'hC);
    rd_onehot = '0;
    in_ports  = 64'h1234_5678_9ABC_DEF0;
    repeat (5) tick();
    check("hold_read.held", 64'(rd_data), 64'hC);
    check_all("hold_read");

    // Pin-to-rd_data latency is exactly three edges with the select held.
    in_ports  = '0;
    apply_reset();
    rd_onehot = 16'h0001;
    repeat (3) tick();
    in_ports[DW-1:0] = 4'h6;
    tick();
    check("latency.edge1", 64'(rd_data), 64'h0);
    tick();
    check("latency.edge2", 64'(rd_data), 64'h0);
    tick();
    check("latency.edge3", 64'(rd_data), 64'h6);
    rd_onehot = '0;

    // Illegal write select: nothing written, error sticks for 20 cycles.
    apply_reset();
    wr_onehot = 16'h0011;
    wr_data   = 4'hF;
    tick();
    idle_inputs();
    check("multi_wr.out_ports", 64'(out_ports), 64'h0);
    check("multi_wr.out_valid", 64'(out_valid), 64'h0);
    check("multi_wr.sel_err", 64'(sel_err), 64'h1);
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("multi_wr.hold%0d", c), 64'(sel_err), 64'h1);
    end

    // Mid-cycle reset clears everything without an edge; the pending write is dropped.
    apply_reset();
    wr_onehot = 16'h8000;
    wr_data   = 4'h9;
    tick();
    check("async.pre", 64'(out_ports[63:60]), 64'h9);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async.now");
    @(posedge clk);
    #1;
    wr_onehot = '0;
    reset     = 1'b0;
    tick();
    check_all("async.after");
    check("async.port15", 64'(out_ports[63:60]), 64'h0);
    idle_inputs();

    // Randomized traffic against the model, with occasional resets.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 80 == 79) begin
        idle_inputs();
        apply_reset();
        check_all("rand.reset");
      end
      wr_onehot = pick_sel(45, 2);
      wr_data   = DW'($urandom);
      rd_onehot = pick_sel(50, 2);
      out_ack   = NP'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) in_ports = {$urandom, $urandom};
      tick();
      check_all($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
